// File: rtl/reset_sequencer.sv
// Board reset sequencer: synchronises and debounces CPU_RESET_n, waits for IOPLL lock, then
// stretches reset before releasing the core. `define RESET_SEQ_EVENT_COUNT_EN builds the event counter.
module reset_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int STRETCH_CYCLES  = 1024
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       cpu_reset_n_async,
    input  logic       pll_locked_async,
    output logic       sys_reset,
    output logic       sys_reset_n,
    output logic [1:0] seq_state,
    output logic [7:0] reset_count
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ST_W = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(STRETCH_CYCLES - 1);

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        STRETCH   = 2'd2,
        RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] btn_sync_q;
    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic                   btn_sync;
    logic                   lock_sync;

    logic                   btn_stable_q, btn_stable_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    state_t                 state_q, state_d;
    logic [ST_W-1:0]        st_cnt_q, st_cnt_d;
    logic                   sys_reset_q, sys_reset_d;

    assign btn_sync  = btn_sync_q[SYNC_STAGES-1];
    assign lock_sync = lock_sync_q[SYNC_STAGES-1];

    // NOTE: every sequential register is updated with <= so all flops sample the pre-edge values.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            btn_sync_q  <= '0;
            lock_sync_q <= '0;
        end else begin
            btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], cpu_reset_n_async};
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked_async};
        end
    end

    // Accept a button change only after it has persisted for DEBOUNCE_CYCLES consecutive cycles.
    // NOTE: each always_comb assigns defaults first so no path leaves an output unassigned (no latch).
    always_comb begin
        btn_stable_d = btn_stable_q;
        db_cnt_d     = '0;
        if (btn_sync != btn_stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_stable_d = ~btn_stable_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            btn_stable_q <= 1'b0;
            db_cnt_q     <= '0;
            state_q      <= HOLD;
            st_cnt_q     <= '0;
            sys_reset_q  <= 1'b1;
        end else begin
            btn_stable_q <= btn_stable_d;
            db_cnt_q     <= db_cnt_d;
            state_q      <= state_d;
            st_cnt_q     <= st_cnt_d;
            sys_reset_q  <= sys_reset_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HOLD:      if (btn_stable_q) state_d = WAIT_LOCK;
            WAIT_LOCK: if (lock_sync) state_d = STRETCH;
            STRETCH: begin
                if (!lock_sync)             state_d = WAIT_LOCK;
                else if (st_cnt_q == ST_LAST) state_d = RUN;
            end
            RUN:       if (!lock_sync) state_d = WAIT_LOCK;
            default:   state_d = HOLD;
        endcase
        // A released-then-pressed button outranks everything, including lock loss.
        if (!btn_stable_q) state_d = HOLD;
    end

    always_comb begin
        st_cnt_d    = st_cnt_q;
        if (state_q == WAIT_LOCK) begin
            st_cnt_d = '0;
        end else if (state_q == STRETCH && state_d == STRETCH) begin
            st_cnt_d = st_cnt_q + 1'b1;
        end
        sys_reset_d = (state_d != RUN);
    end

    assign sys_reset   = sys_reset_q;
    assign sys_reset_n = ~sys_reset_q;
    assign seq_state   = state_q;

`ifdef RESET_SEQ_EVENT_COUNT_EN
    logic [7:0] evt_cnt_q, evt_cnt_d;

    // Counts RUN -> HOLD exits caused by the debounced button, saturating at 255.
    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (state_q == RUN && !btn_stable_q && evt_cnt_q != 8'hFF) begin
            evt_cnt_d = evt_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            evt_cnt_q <= '0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign reset_count = evt_cnt_q;
`else
    assign reset_count = 8'd0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, STRETCH_CYCLES=8.
// Table-driven release sequence plus hand-written glitch, lock-loss, priority and reset cases.
module tb_reset_sequencer;

    localparam int SYNC      = 2;
    localparam int DB        = 4;
    localparam int ST        = 8;
    localparam int REL_EDGES = SYNC + DB + 2 + ST;

`ifdef RESET_SEQ_EVENT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_STR  = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    logic       clk_clk           = 1'b0;
    logic       reset_reset       = 1'b1;
    logic       cpu_reset_n_async = 1'b1;
    logic       pll_locked_async  = 1'b1;
    logic       sys_reset;
    logic       sys_reset_n;
    logic [1:0] seq_state;
    logic [7:0] reset_count;

    typedef struct {
        logic       rst;
        logic       btn;
        logic       lock;
        logic [1:0] st;
        logic       sr;
    } vec_t;

    typedef struct {
        logic [1:0] st;
        logic       sr;
        string      tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_cnt  = 0;

    always #5 clk_clk = ~clk_clk;

    reset_sequencer #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DB),
        .STRETCH_CYCLES (ST)
    ) dut (
        .clk_clk          (clk_clk),
        .reset_reset      (reset_reset),
        .cpu_reset_n_async(cpu_reset_n_async),
        .pll_locked_async (pll_locked_async),
        .sys_reset        (sys_reset),
        .sys_reset_n      (sys_reset_n),
        .seq_state        (seq_state),
        .reset_count      (reset_count)
    );

    // Expected state k edges after the first edge sampling a released button (lock stable).
    function automatic logic [1:0] release_state(input int k);
        if (k <= SYNC + DB)          return S_HOLD;
        else if (k == SYNC + DB + 1) return S_WAIT;
        else if (k < REL_EDGES)      return S_STR;
        else                         return S_RUN;
    endfunction

    // Expected state j edges after lock returns while the button is stable.
    function automatic logic [1:0] lock_state(input int j);
        if (j <= SYNC)           return S_WAIT;
        else if (j <= SYNC + ST) return S_STR;
        else                     return S_RUN;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic btn, input logic lock,
                        input logic [1:0] st, input logic sr, input string tag);
        exp_t e;
        @(negedge clk_clk);
        reset_reset       = rst;
        cpu_reset_n_async = btn;
        pll_locked_async  = lock;
        sb.push_back('{st, sr, tag});
        @(posedge clk_clk);
        #1;
        e = sb.pop_front();
        check({e.tag, "_state"}, 32'(seq_state), 32'(e.st));
        check({e.tag, "_sys_reset"}, 32'(sys_reset), 32'(e.sr));
        check({e.tag, "_sys_reset_n"}, 32'(sys_reset_n), e.sr ? 32'd0 : 32'd1);
    endtask

    task automatic wait_state(input logic [1:0] target, input logic btn, input logic lock,
                              input int budget, input string tag);
        int n = 0;
        while (seq_state !== target && n < budget) begin
            @(negedge clk_clk);
            reset_reset       = 1'b0;
            cpu_reset_n_async = btn;
            pll_locked_async  = lock;
            @(posedge clk_clk);
            #1;
            n++;
        end
        check(tag, 32'(seq_state), 32'(target));
    endtask

    initial begin
        // Release from reset with lock already stable: sys_reset must fall on edge REL_EDGES.
        vecs.push_back('{1'b1, 1'b1, 1'b1, S_HOLD, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 1'b1, S_HOLD, 1'b1});
        for (int k = 1; k <= REL_EDGES + 2; k++) begin
            vecs.push_back('{1'b0, 1'b1, 1'b1, release_state(k), release_state(k) != S_RUN});
        end
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].btn, vecs[i].lock, vecs[i].st, vecs[i].sr,
                 $sformatf("t1_v%0d", i));
        end
        check("t1_count", 32'(reset_count), 32'(exp_cnt));

        // Short glitch is filtered; a 6-cycle press resets on edge 7 and then re-releases.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, S_RUN, 1'b0, "t2_glitch");
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, S_RUN, 1'b0, "t2_settle");
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, S_RUN, 1'b0, "t2_press");
        if (CNT_EN) exp_cnt++;
        step(1'b0, 1'b1, 1'b1, S_HOLD, 1'b1, "t2_edge7");
        check("t2_count", 32'(reset_count), 32'(exp_cnt));
        for (int k = 2; k <= REL_EDGES; k++) begin
            step(1'b0, 1'b1, 1'b1, release_state(k), release_state(k) != S_RUN, "t2_rec");
        end

        // Lock loss in RUN, then a stretch interrupted by lock loss, then a full stretch.
        step(1'b0, 1'b1, 1'b0, S_RUN, 1'b0, "t4_drop1");
        step(1'b0, 1'b1, 1'b0, S_RUN, 1'b0, "t4_drop2");
        step(1'b0, 1'b1, 1'b0, S_WAIT, 1'b1, "t4_drop3");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, S_WAIT, 1'b1, "t4_unlocked");
        for (int j = 1; j <= 6; j++) begin
            step(1'b0, 1'b1, 1'b1, lock_state(j), 1'b1, "t4_partial");
        end
        step(1'b0, 1'b1, 1'b0, S_STR, 1'b1, "t4_redrop1");
        step(1'b0, 1'b1, 1'b0, S_STR, 1'b1, "t4_redrop2");
        step(1'b0, 1'b1, 1'b0, S_WAIT, 1'b1, "t4_redrop3");
        for (int j = 1; j <= SYNC + ST + 1; j++) begin
            step(1'b0, 1'b1, 1'b1, lock_state(j), lock_state(j) != S_RUN, "t4_relock");
        end

        // Debounced press and lock loss land on the same edge: HOLD must win.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, S_RUN, 1'b0, "t5_press");
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, S_RUN, 1'b0, "t5_both");
        if (CNT_EN) exp_cnt++;
        step(1'b0, 1'b0, 1'b0, S_HOLD, 1'b1, "t5_prio");
        step(1'b0, 1'b0, 1'b0, S_HOLD, 1'b1, "t5_stay");
        check("t5_count", 32'(reset_count), 32'(exp_cnt));

        // Lock held low after release: parked in WAIT_LOCK until lock arrives.
        step(1'b1, 1'b1, 1'b0, S_HOLD, 1'b1, "t3_reset");
        exp_cnt = 0;
        check("t3_count_clr", 32'(reset_count), 32'(exp_cnt));
        for (int k = 1; k <= 30; k++) begin
            step(1'b0, 1'b1, 1'b0, (k <= SYNC + DB) ? S_HOLD : S_WAIT, 1'b1, "t3_nolock");
        end
        for (int j = 1; j <= SYNC + ST + 1; j++) begin
            step(1'b0, 1'b1, 1'b1, lock_state(j), lock_state(j) != S_RUN, "t3_lock");
        end

        // Synchronous reset in STRETCH, then a fresh full-latency release.
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b1, 1'b1, S_RUN, 1'b0, "t6_pre");
        end
        step(1'b1, 1'b1, 1'b1, S_HOLD, 1'b1, "t6_reset_a");
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b1, 1'b1, release_state(k), 1'b1, "t6_to_stretch");
        end
        step(1'b1, 1'b1, 1'b1, S_HOLD, 1'b1, "t6_mid_stretch_rst");
        check("t6_count_clr", 32'(reset_count), 32'(exp_cnt));
        for (int k = 1; k <= REL_EDGES; k++) begin
            step(1'b0, 1'b1, 1'b1, release_state(k), release_state(k) != S_RUN, "t6_rel");
        end

        // 300 button resets: counter saturates at 255 when built.
        for (int n = 1; n <= 300; n++) begin
            wait_state(S_HOLD, 1'b0, 1'b1, 20, "t6_press_to_hold");
            if (CNT_EN && exp_cnt < 255) exp_cnt++;
            wait_state(S_RUN, 1'b1, 1'b1, 40, "t6_release_to_run");
            if (n == 255) check("t6_count_255", 32'(reset_count), 32'(exp_cnt));
        end
        check("t6_count_sat", 32'(reset_count), 32'(exp_cnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Upstream stage of the platform's Qsys system: owns the raw board reset sources and generates the synchronous, debounced, stretched reset that drives the system's reset_reset input.
- Synchronises the CPU_RESET_n push-button and the IOPLL lock flag, debounces the button, waits for PLL lock, then holds reset for a fixed stretch before releasing the core.
- Also exports a state code for the board LEDs.

Parameters:
SYNC_STAGES, 2, flops per asynchronous-input synchroniser (>=2)
DEBOUNCE_CYCLES, 1000000, consecutive cycles the button must differ from its stable value before the change is accepted (20 ms at 50 MHz)
STRETCH_CYCLES, 1024, cycles reset is held after lock before release (>=1)

Ports:
clk_clk  input  1  system clock (CLK_50_B3I domain)
reset_reset  input  1  synchronous active-high reset, from init-done logic
cpu_reset_n_async  input  1  raw push-button, active low, asynchronous
pll_locked_async  input  1  IOPLL locked flag, asynchronous
sys_reset  output  1  active-high reset to downstream system
sys_reset_n  output  1  complement of sys_reset
seq_state  output  2  current state: 0 HOLD, 1 WAIT_LOCK, 2 STRETCH, 3 RUN
reset_count  output  8  button-initiated reset count (see Optional Feature)

Behaviour:
- Single clock. All flops reset synchronously while reset_reset=1.
- Synchronisers:
  - cpu_reset_n_async and pll_locked_async each pass through SYNC_STAGES flops.
  - Reset value of every stage is 0 (button pressed, PLL unlocked).
- Debounce:
  - btn_stable has reset value 0. The counter is $clog2(DEBOUNCE_CYCLES+1) bits with reset value 0.
  - When the synced button equals btn_stable, the counter clears. Otherwise it increments.
  - On the edge where the counter would reach DEBOUNCE_CYCLES, btn_stable toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes btn_stable.
- FSM (reset state HOLD):
  - HOLD: leave for WAIT_LOCK when btn_stable=1.
  - WAIT_LOCK: leave for STRETCH when lock_sync=1. The stretch counter is loaded with 0.
  - STRETCH: if the counter equals STRETCH_CYCLES-1, go to RUN; otherwise increment. The counter is $clog2(STRETCH_CYCLES) bits, minimum 1.
  - RUN: terminal while the inputs are good.
  - From any state, btn_stable=0 goes to HOLD. This has the highest priority and wins over simultaneous lock loss.
  - From STRETCH or RUN, lock_sync=0 goes to WAIT_LOCK. The stretch restarts from 0 on the next lock.
- Outputs:
  - sys_reset is registered as sys_reset <= (next_state != RUN). It deasserts on the same edge the state becomes RUN and reasserts on the same edge the state leaves RUN.
  - sys_reset reset value is 1; sys_reset_n reset value is 0.
  - seq_state is the state register; reset value 0.
- Release latency: with lock already stable, sys_reset falls exactly SYNC_STAGES + DEBOUNCE_CYCLES + 2 + STRETCH_CYCLES edges after the first edge that samples reset_reset=0 with the button released.
- Reset mid-operation: reset_reset=1 in any state returns everything to reset values on the next edge. sys_reset=1 takes effect immediately at that edge.

Optional Feature:
- Macro: RESET_SEQ_EVENT_COUNT_EN.
- Defined:
  - reset_count is an 8-bit counter, reset value 0.
  - It increments on each transition into HOLD caused by btn_stable falling while in RUN.
  - It saturates at 255 and is cleared only by reset_reset.
- Not defined: reset_count is tied to 0 and no counter logic is built.

Test Plan:
(Parameters SYNC_STAGES=2, DEBOUNCE_CYCLES=4, STRETCH_CYCLES=8.)
1. Button released and lock high throughout; drop reset_reset -> seq_state steps 0,1,2,3. sys_reset falls at edge 16 exactly; sys_reset_n rises at the same edge.
2. In RUN, pulse button low for 3 cycles -> no state change, sys_reset stays 0. Pulse low for 6 cycles -> sys_reset rises on edge 2+4+1 after the press; seq_state=0; reset_count goes 0->1 (macro defined) or stays 0 (undefined).
3. Lock held low after button release -> FSM stays in WAIT_LOCK with sys_reset=1 indefinitely. Raise lock -> RUN reached 2+1+8 edges later.
4. Drop lock in RUN -> sys_reset=1 and seq_state=1 on edge 3 after the drop. Restore lock -> full 8-cycle stretch repeats.
5. Drop lock and press button so btn_stable falls on the same edge lock_sync falls -> next state HOLD, not WAIT_LOCK.
6. Assert reset_reset while in STRETCH -> next edge: seq_state=0, sys_reset=1, counters 0. Perform 300 button resets with the macro defined -> reset_count=255.
